// File: rtl/clap_detector.sv
// Double-clap detector operating on a stream of frame energies.
// A clap is a run of above-threshold beats (at most MAX_CLAP long); two claps
// separated by MIN_GAP..MAX_GAP below-threshold beats produce a one-cycle
// clap_pulse and toggle light_state. After a detection or rejection the
// block ignores HOLDOFF beats before listening again.
// Optional feature: define CLAP_DETECTOR_HYSTERESIS_EN to release a clap only
// when energy falls below THRESHOLD/2 (classification in IDLE/GAP unchanged).
module clap_detector #(
    parameter int unsigned                 ENERGY_WIDTH = 32,
    parameter logic [ENERGY_WIDTH-1:0]     THRESHOLD    = 'h0100_0000,
    parameter int unsigned                 MAX_CLAP     = 4,
    parameter int unsigned                 MIN_GAP      = 2,
    parameter int unsigned                 MAX_GAP      = 20,
    parameter int unsigned                 HOLDOFF      = 10
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic [ENERGY_WIDTH-1:0] energy_data,
    input  logic                    energy_valid,
    output logic                    energy_ready,
    output logic                    clap_pulse,
    output logic                    light_state,
    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLAP1 = 3'd1,
        GAP   = 3'd2,
        CLAP2 = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [16:0] MAX_CLAP_C = 17'(MAX_CLAP);
    localparam logic [16:0] MIN_GAP_C  = 17'(MIN_GAP);
    localparam logic [16:0] MAX_GAP_C  = 17'(MAX_GAP);
    localparam logic [16:0] HOLDOFF_C  = 17'(HOLDOFF);

    state_t      state, state_next;
    logic [15:0] cnt, cnt_next;
    logic        pulse_next;
    logic        light_next;
    logic        beat;
    logic        above;
    logic        clap_above;
    logic [15:0] cnt_sat;
    logic [16:0] cnt_plus;

    assign beat     = energy_valid && energy_ready;
    assign above    = (energy_data >= THRESHOLD);
    assign cnt_sat  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    // Widened so the "would exceed" comparisons never wrap at saturation.
    assign cnt_plus = {1'b0, cnt} + 17'd1;
    assign busy     = (state != IDLE);

    // Inside a clap, decide whether this beat extends it.
`ifdef CLAP_DETECTOR_HYSTERESIS_EN
    assign clap_above = (energy_data >= (THRESHOLD >> 1));
`else
    assign clap_above = above;
`endif

    // State, counter and registered outputs.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            cnt          <= '0;
            energy_ready <= 1'b0;
            clap_pulse   <= 1'b0;
            light_state  <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            energy_ready <= 1'b1;
            clap_pulse   <= pulse_next;
            light_state  <= light_next;
        end
    end

    // Next-state, counter and output decode; only beats advance anything.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;
        light_next = light_state;
        if (beat) begin
            unique case (state)
                IDLE: begin
                    if (above) begin
                        state_next = CLAP1;
                        cnt_next   = 16'd1;
                    end
                end
                CLAP1: begin
                    if (clap_above) begin
                        if (cnt_plus > MAX_CLAP_C) begin
                            state_next = HOLD;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_sat;
                        end
                    end else begin
                        // The releasing beat is already the first gap beat.
                        state_next = GAP;
                        cnt_next   = 16'd1;
                    end
                end
                GAP: begin
                    if (above) begin
                        state_next = ({1'b0, cnt} >= MIN_GAP_C) ? CLAP2 : HOLD;
                        cnt_next   = ({1'b0, cnt} >= MIN_GAP_C) ? 16'd1 : 16'd0;
                    end else if (cnt_plus > MAX_GAP_C) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_sat;
                    end
                end
                CLAP2: begin
                    if (clap_above) begin
                        if (cnt_plus > MAX_CLAP_C) begin
                            state_next = HOLD;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_sat;
                        end
                    end else begin
                        state_next = HOLD;
                        cnt_next   = '0;
                        pulse_next = 1'b1;
                        light_next = ~light_state;
                    end
                end
                HOLD: begin
                    if (cnt_plus >= HOLDOFF_C) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_sat;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clap_detector.sv
// Directed bench for clap_detector with default parameters.
// Expectations follow the macro CLAP_DETECTOR_HYSTERESIS_EN when defined.
module tb_clap_detector;

    localparam logic [31:0] A   = 32'h0200_0000;
    localparam logic [31:0] B   = 32'h0000_1000;
    localparam logic [31:0] THR = 32'h0100_0000;
    localparam logic [31:0] MID = 32'h00C0_0000;

    logic        clock;
    logic        nreset;
    logic [31:0] energy_data;
    logic        energy_valid;
    logic        energy_ready;
    logic        clap_pulse;
    logic        light_state;
    logic        busy;

    int unsigned n_checks;
    int unsigned n_errors;

    clap_detector dut (
        .clock        (clock),
        .nreset       (nreset),
        .energy_data  (energy_data),
        .energy_valid (energy_valid),
        .energy_ready (energy_ready),
        .clap_pulse   (clap_pulse),
        .light_state  (light_state),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One beat; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] d);
        @(negedge clock);
        energy_data  = d;
        energy_valid = 1'b1;
        @(posedge clock);
        #1;
        energy_valid = 1'b0;
    endtask

    // From HOLD entry: 9 beats stay busy, the 10th returns to IDLE.
    task automatic drain_hold(input string tag);
        repeat (9) send(B);
        check({tag, "_hold9_busy"}, busy, 1);
        send(B);
        check({tag, "_hold10_busy"}, busy, 0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        nreset       = 1'b0;
        energy_data  = '0;
        energy_valid = 1'b0;
        #3;
        check("rst_ready", energy_ready, 0);
        check("rst_pulse", clap_pulse, 0);
        check("rst_light", light_state, 0);
        check("rst_busy",  busy, 0);
        @(negedge clock);
        @(negedge clock);
        nreset = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_rst", energy_ready, 1);

        // Basic double clap A,B,B,B,A,B with idle cycles inserted.
        send(A);
        check("t1_clap1_busy", busy, 1);
        energy_data = B;
        repeat (5) @(posedge clock);
        #1;
        check("t1_idle_cycles_busy", busy, 1);
        send(B); send(B); send(B); send(A);
        check("t1_pre_pulse", clap_pulse, 0);
        send(B);
        check("t1_pulse", clap_pulse, 1);
        check("t1_light", light_state, 1);
        check("t1_busy_hold", busy, 1);
        @(posedge clock);
        #1;
        check("t1_pulse_one_cycle", clap_pulse, 0);
        drain_hold("t1");

        // Gap too short: A,B,A -> HOLD without pulse.
        send(A); send(B); send(A);
        check("t2_no_pulse", clap_pulse, 0);
        send(B);
        check("t2_no_pulse_b", clap_pulse, 0);
        repeat (8) send(B);
        check("t2_hold9_busy", busy, 1);
        send(B);
        check("t2_idle_busy", busy, 0);
        check("t2_light_kept", light_state, 1);

        // Just below threshold is ignored in IDLE; exactly threshold is above.
        send(THR - 32'd1);
        check("t3_below_idle", busy, 0);
        repeat (5) send(THR);
        check("t3_overlong_busy", busy, 1);
        check("t3_overlong_pulse", clap_pulse, 0);
        drain_hold("t3");

        // Gap timeout: A + 21 B -> IDLE; next A enters CLAP1.
        send(A);
        repeat (20) send(B);
        check("t4_gap20_busy", busy, 1);
        send(B);
        check("t4_gap21_idle", busy, 0);
        send(A);
        check("t4_new_clap_busy", busy, 1);
        send(B);
        check("t4_clap1_not_clap2", clap_pulse, 0);

        // Asynchronous reset during GAP.
        #2;
        nreset = 1'b0;
        #1;
        check("t5_rst_busy",  busy, 0);
        check("t5_rst_light", light_state, 0);
        check("t5_rst_ready", energy_ready, 0);
        check("t5_rst_pulse", clap_pulse, 0);
        @(posedge clock);
        @(negedge clock);
        nreset = 1'b1;
        send(B);
        check("t5_restart_idle", busy, 0);
        send(A); send(B); send(B); send(A); send(B);
        check("t5_pulse", clap_pulse, 1);
        check("t5_light", light_state, 1);
        drain_hold("t5");

        // Mid-level energy: detects with or without hysteresis.
        send(A);
        repeat (3) send(MID);
        send(B); send(B); send(A);
        check("t6_pre_pulse", clap_pulse, 0);
        send(B);
        check("t6_pulse", clap_pulse, 1);
        check("t6_light", light_state, 0);
        drain_hold("t6");

        // A + 5 MID: over-length clap with hysteresis, plain gap without.
        send(A);
        repeat (5) send(MID);
        check("t7_busy", busy, 1);
        repeat (10) send(B);
`ifdef CLAP_DETECTOR_HYSTERESIS_EN
        check("t7_after10", busy, 0);
`else
        check("t7_after10", busy, 1);
`endif
        check("t7_no_pulse", clap_pulse, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
